// File: rtl/serial_uart_bridge.sv
// Purpose: CPU serial-port <-> UART line bridge with RX/TX FIFOs; 8N1, or 8E1 when SERIAL_BRIDGE_PARITY_EN is defined.
// Latency: TX line drops 2 cycles after an accepted write; RX byte visible within CLKS_PER_BIT+4 cycles of stop-bit midpoint.
// Backpressure: cpu_serial_ready_in low while TX FIFO full (writes dropped, tx_overflow); RX bytes into a full FIFO dropped (rx_overflow).
module serial_uart_bridge #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       uart_rx_in,
    output logic       uart_tx_out,
    output logic [7:0] cpu_serial_in,
    output logic       cpu_serial_valid_in,
    output logic       cpu_serial_ready_in,
    input  logic [7:0] cpu_serial_out,
    input  logic       cpu_serial_rden_out,
    input  logic       cpu_serial_wren_out,
    input  logic       clr_status,
    output logic       rx_overflow,
    output logic       tx_overflow,
    output logic       frame_error
);
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [CW-1:0]      BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]      HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [FIFO_AW:0]   PTR_ONE   = (FIFO_AW + 1)'(1);

`ifdef SERIAL_BRIDGE_PARITY_EN
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_BREAK} rx_state_t;
    logic       tx_par_q;
    logic       rx_perr_q;
`else
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
`endif

    // FIFO state: pointers carry an extra wrap bit to tell full from empty
    logic [FIFO_AW:0] rx_wr_q, rx_rd_q, tx_wr_q, tx_rd_q;
    logic [7:0]       rx_mem_q [DEPTH];
    logic [7:0]       tx_mem_q [DEPTH];
    logic             rx_empty, rx_full, tx_empty, tx_full;
    logic             rx_do_push, rx_do_pop, tx_do_push, tx_do_pop;
    logic [7:0]       tx_head;

    tx_state_t        tx_state_q;
    logic [CW-1:0]    tx_cnt_q;
    logic [2:0]       tx_idx_q;
    logic [7:0]       tx_shift_q;
    logic             uart_tx_q;

    rx_state_t        rx_state_q;
    logic [1:0]       rx_sync_q;
    logic             rx_line;
    logic [CW-1:0]    rx_cnt_q;
    logic [2:0]       rx_idx_q;
    logic [7:0]       rx_shift_q;
    logic             rx_push_q;
    logic             rx_ferr_q;

    logic             rx_ovf_q, tx_ovf_q, ferr_q;

    assign rx_empty   = (rx_wr_q == rx_rd_q);
    assign rx_full    = (rx_wr_q[FIFO_AW-1:0] == rx_rd_q[FIFO_AW-1:0]) && (rx_wr_q[FIFO_AW] != rx_rd_q[FIFO_AW]);
    assign tx_empty   = (tx_wr_q == tx_rd_q);
    assign tx_full    = (tx_wr_q[FIFO_AW-1:0] == tx_rd_q[FIFO_AW-1:0]) && (tx_wr_q[FIFO_AW] != tx_rd_q[FIFO_AW]);

    // Full/empty come from registered pointers, so a same-cycle pop never rescues a write
    assign rx_do_push = rx_push_q && !rx_full;
    assign rx_do_pop  = cpu_serial_rden_out && !rx_empty;
    assign tx_do_push = cpu_serial_wren_out && !tx_full;
    assign tx_do_pop  = !tx_empty && ((tx_state_q == TX_IDLE) ||
                                      ((tx_state_q == TX_STOP) && (tx_cnt_q == BIT_LAST)));
    assign tx_head    = tx_mem_q[tx_rd_q[FIFO_AW-1:0]];

    assign cpu_serial_in       = rx_empty ? 8'h00 : rx_mem_q[rx_rd_q[FIFO_AW-1:0]];
    assign cpu_serial_valid_in = !rx_empty;
    assign cpu_serial_ready_in = !tx_full;
    assign uart_tx_out         = uart_tx_q;
    assign rx_line             = rx_sync_q[1];
    assign rx_overflow         = rx_ovf_q;
    assign tx_overflow         = tx_ovf_q;
    assign frame_error         = ferr_q;

    // FIFO pointer update for both directions
    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_wr_q <= '0;
            rx_rd_q <= '0;
            tx_wr_q <= '0;
            tx_rd_q <= '0;
        end else begin
            if (rx_do_push) rx_wr_q <= rx_wr_q + PTR_ONE;
            if (rx_do_pop)  rx_rd_q <= rx_rd_q + PTR_ONE;
            if (tx_do_push) tx_wr_q <= tx_wr_q + PTR_ONE;
            if (tx_do_pop)  tx_rd_q <= tx_rd_q + PTR_ONE;
        end
    end

    // FIFO storage is not reset; cpu_serial_in is forced to 0 whenever RX is empty
    always_ff @(posedge clock) begin
        if (rx_do_push) rx_mem_q[rx_wr_q[FIFO_AW-1:0]] <= rx_shift_q;
        if (tx_do_push) tx_mem_q[tx_wr_q[FIFO_AW-1:0]] <= cpu_serial_out;
    end

    // TX engine: line register follows the state one cycle later, giving the 2-cycle start latency
    always_ff @(posedge clock) begin
        if (!reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            uart_tx_q  <= 1'b1;
`ifdef SERIAL_BRIDGE_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            case (tx_state_q)
                TX_START: uart_tx_q <= 1'b0;
                TX_DATA:  uart_tx_q <= tx_shift_q[0];
`ifdef SERIAL_BRIDGE_PARITY_EN
                TX_PAR:   uart_tx_q <= tx_par_q;
`endif
                default:  uart_tx_q <= 1'b1;
            endcase
            tx_cnt_q <= (tx_cnt_q == BIT_LAST || tx_state_q == TX_IDLE) ? '0 : tx_cnt_q + CW'(1);
            case (tx_state_q)
                TX_IDLE: if (tx_do_pop) begin
                    tx_shift_q <= tx_head;
`ifdef SERIAL_BRIDGE_PARITY_EN
                    tx_par_q   <= ^tx_head;
`endif
                    tx_state_q <= TX_START;
                end
                TX_START: if (tx_cnt_q == BIT_LAST) begin
                    tx_idx_q   <= '0;
                    tx_state_q <= TX_DATA;
                end
                TX_DATA: if (tx_cnt_q == BIT_LAST) begin
                    tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                    tx_idx_q   <= tx_idx_q + 3'd1;
`ifdef SERIAL_BRIDGE_PARITY_EN
                    if (tx_idx_q == 3'd7) tx_state_q <= TX_PAR;
`else
                    if (tx_idx_q == 3'd7) tx_state_q <= TX_STOP;
`endif
                end
`ifdef SERIAL_BRIDGE_PARITY_EN
                TX_PAR: if (tx_cnt_q == BIT_LAST) tx_state_q <= TX_STOP;
`endif
                TX_STOP: if (tx_cnt_q == BIT_LAST) begin
                    if (tx_do_pop) begin
                        tx_shift_q <= tx_head;
`ifdef SERIAL_BRIDGE_PARITY_EN
                        tx_par_q   <= ^tx_head;
`endif
                        tx_state_q <= TX_START;
                    end else begin
                        tx_state_q <= TX_IDLE;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    // RX engine: two-flop synchroniser, mid-bit sampling, push/error pulses registered
    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_sync_q  <= 2'b11;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_push_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
`ifdef SERIAL_BRIDGE_PARITY_EN
            rx_perr_q  <= 1'b0;
`endif
        end else begin
            rx_sync_q <= {rx_sync_q[0], uart_rx_in};
            rx_push_q <= 1'b0;
            rx_ferr_q <= 1'b0;
            rx_cnt_q  <= rx_cnt_q + CW'(1);
            case (rx_state_q)
                RX_IDLE: begin
                    rx_cnt_q <= '0;
                    if (!rx_line) rx_state_q <= RX_START;
                end
                RX_START: if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_q   <= '0;
                    rx_idx_q   <= '0;
                    rx_state_q <= rx_line ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_q   <= '0;
                    rx_shift_q <= {rx_line, rx_shift_q[7:1]};
                    rx_idx_q   <= rx_idx_q + 3'd1;
`ifdef SERIAL_BRIDGE_PARITY_EN
                    if (rx_idx_q == 3'd7) rx_state_q <= RX_PAR;
`else
                    if (rx_idx_q == 3'd7) rx_state_q <= RX_STOP;
`endif
                end
`ifdef SERIAL_BRIDGE_PARITY_EN
                RX_PAR: if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_q   <= '0;
                    rx_perr_q  <= rx_line ^ (^rx_shift_q);
                    rx_state_q <= RX_STOP;
                end
`endif
                RX_STOP: if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_q <= '0;
                    if (rx_line) begin
`ifdef SERIAL_BRIDGE_PARITY_EN
                        rx_push_q <= !rx_perr_q;
                        rx_ferr_q <= rx_perr_q;
`else
                        rx_push_q <= 1'b1;
`endif
                        rx_state_q <= RX_IDLE;
                    end else begin
                        rx_ferr_q  <= 1'b1;
                        rx_state_q <= RX_BREAK;
                    end
                end
                RX_BREAK: begin
                    rx_cnt_q <= '0;
                    if (rx_line) rx_state_q <= RX_IDLE;
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // Sticky status: a set event in the same cycle as clr_status wins
    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_ovf_q <= 1'b0;
            tx_ovf_q <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            rx_ovf_q <= (rx_ovf_q && !clr_status) || (rx_push_q && rx_full);
            tx_ovf_q <= (tx_ovf_q && !clr_status) || (cpu_serial_wren_out && tx_full);
            ferr_q   <= (ferr_q && !clr_status) || rx_ferr_q;
        end
    end
endmodule

// File: tb/tb_serial_uart_bridge.sv
`timescale 1ns/1ps
module tb_serial_uart_bridge;
    localparam int CPB   = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
`ifdef SERIAL_BRIDGE_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       uart_rx_in = 1'b1;
    logic       uart_tx_out;
    logic [7:0] cpu_serial_in;
    logic       cpu_serial_valid_in;
    logic       cpu_serial_ready_in;
    logic [7:0] cpu_serial_out = 8'h00;
    logic       cpu_serial_rden_out = 1'b0;
    logic       cpu_serial_wren_out = 1'b0;
    logic       clr_status = 1'b0;
    logic       rx_overflow, tx_overflow, frame_error;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] tx_seen[$];

    serial_uart_bridge #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .clock(clock), .reset(reset), .uart_rx_in(uart_rx_in), .uart_tx_out(uart_tx_out),
        .cpu_serial_in(cpu_serial_in), .cpu_serial_valid_in(cpu_serial_valid_in),
        .cpu_serial_ready_in(cpu_serial_ready_in), .cpu_serial_out(cpu_serial_out),
        .cpu_serial_rden_out(cpu_serial_rden_out), .cpu_serial_wren_out(cpu_serial_wren_out),
        .clr_status(clr_status), .rx_overflow(rx_overflow), .tx_overflow(tx_overflow),
        .frame_error(frame_error)
    );

    always #5 clock = ~clock;

    // Line level of UART frame bit idx: start, 8 data LSB first, [even parity], stop
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (idx == NBITS - 1) return 1'b1;
        return ^b;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic cpu_write(input logic [7:0] d);
        cpu_serial_out = d;
        cpu_serial_wren_out = 1'b1;
        step();
        cpu_serial_wren_out = 1'b0;
    endtask

    task automatic cpu_read();
        cpu_serial_rden_out = 1'b1;
        step();
        cpu_serial_rden_out = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_v);
        for (int i = 0; i < NBITS; i++) begin
            uart_rx_in = (i == NBITS - 1) ? stop_v : frame_bit(b, i);
            repeat (CPB) step();
        end
    endtask

    task automatic wait_valid(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < CPB + 8; i++) begin
            if (cpu_serial_valid_in === 1'b1) begin
                seen = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Independent UART receiver on the TX pin: decodes complete frames into tx_seen
    initial begin : tx_monitor
        logic [7:0] b;
        logic ok;
        forever begin
            @(posedge clock); #2;
            if (reset === 1'b1 && uart_tx_out === 1'b0) begin
                ok = 1'b1;
                b  = 8'h00;
                repeat (CPB / 2) begin @(posedge clock); #2; end
                if (uart_tx_out !== 1'b0) ok = 1'b0;
                for (int i = 0; i < NBITS - 1; i++) begin
                    repeat (CPB) begin
                        @(posedge clock); #2;
                        if (reset !== 1'b1) ok = 1'b0;
                    end
                    if (i < 8) b[i] = uart_tx_out;
                    else if (i == NBITS - 2) begin if (uart_tx_out !== 1'b1) ok = 1'b0; end
                    else if (uart_tx_out !== ^b) ok = 1'b0;
                end
                if (ok) tx_seen.push_back(b);
            end
        end
    end

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        n_tests++; if (uart_tx_out !== 1'b1) begin n_fail++; $display("FAIL reset_tx_line: got %b want 1", uart_tx_out); end
        n_tests++; if (cpu_serial_ready_in !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cpu_serial_ready_in); end
        n_tests++; if (cpu_serial_valid_in !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", cpu_serial_valid_in); end
        n_tests++; if (cpu_serial_in !== 8'h00) begin n_fail++; $display("FAIL reset_serial_in: got %h want 00", cpu_serial_in); end
        n_tests++; if ({rx_overflow, tx_overflow, frame_error} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 000", {rx_overflow, tx_overflow, frame_error}); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_tx();
        logic [87:0] obs, expv;
        int nc;
        nc = 2 * NBITS * CPB;
        obs = '0;
        expv = '0;
        tx_seen.delete();
        cpu_write(8'hA5);
        cpu_write(8'h3C);
        n_tests++; if (uart_tx_out !== 1'b1) begin n_fail++; $display("FAIL tx_latency_edge1: line %b want 1", uart_tx_out); end
        for (int i = 0; i < nc; i++) begin
            step();
            obs[i]  = uart_tx_out;
            expv[i] = frame_bit((i < NBITS * CPB) ? 8'hA5 : 8'h3C, (i / CPB) % NBITS);
        end
        n_tests++; if (obs !== expv) begin n_fail++; $display("FAIL tx_waveform_b2b: got %h want %h", obs, expv); end
        step();
        n_tests++; if (uart_tx_out !== 1'b1) begin n_fail++; $display("FAIL tx_idle_after: line %b want 1", uart_tx_out); end
        n_tests++; if (tx_seen.size() != 2 || tx_seen[0] !== 8'hA5 || tx_seen[1] !== 8'h3C) begin
            n_fail++; $display("FAIL tx_decoded: got %0d bytes want 2 (A5,3C)", tx_seen.size()); end
    endtask

    task automatic test_rx();
        logic seen;
        send_rx(8'h5A, 1'b1);
        uart_rx_in = 1'b1;
        wait_valid(seen);
        n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rx_valid_timeout: valid %b want 1", cpu_serial_valid_in); end
        n_tests++; if (cpu_serial_in !== 8'h5A) begin n_fail++; $display("FAIL rx_data: got %h want 5a", cpu_serial_in); end
        cpu_read();
        n_tests++; if (cpu_serial_valid_in !== 1'b0) begin n_fail++; $display("FAIL rx_after_pop: valid %b want 0", cpu_serial_valid_in); end
    endtask

    task automatic test_tx_overflow();
        logic [7:0] exp_q[$];
        logic [7:0] d;
        tx_seen.delete();
        d = 8'($urandom_range(0, 255));
        exp_q.push_back(d);
        cpu_write(d);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom_range(0, 255));
            n_tests++; if (cpu_serial_ready_in !== (exp_q.size() - 1 < DEPTH)) begin
                n_fail++; $display("FAIL txovf_ready_%0d: got %b want %b", i, cpu_serial_ready_in, (exp_q.size() - 1 < DEPTH)); end
            if (exp_q.size() - 1 < DEPTH) exp_q.push_back(d);
            cpu_write(d);
        end
        n_tests++; if (tx_overflow !== 1'b1) begin n_fail++; $display("FAIL txovf_flag: got %b want 1", tx_overflow); end
        n_tests++; if (cpu_serial_ready_in !== 1'b0) begin n_fail++; $display("FAIL txovf_ready_full: got %b want 0", cpu_serial_ready_in); end
        repeat (5 * NBITS * CPB + 20) step();
        n_tests++; if (tx_seen.size() != exp_q.size()) begin
            n_fail++; $display("FAIL txovf_count: got %0d bytes want %0d", tx_seen.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < tx_seen.size(); i++) begin
            n_tests++; if (tx_seen[i] !== exp_q[i]) begin n_fail++; $display("FAIL txovf_byte_%0d: got %h want %h", i, tx_seen[i], exp_q[i]); end
        end
    endtask

    task automatic test_rx_overflow();
        logic [7:0] model[$];
        logic [7:0] d;
        logic exp_ovf;
        exp_ovf = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom_range(0, 255));
            if (model.size() < DEPTH) model.push_back(d); else exp_ovf = 1'b1;
            send_rx(d, 1'b1);
        end
        uart_rx_in = 1'b1;
        repeat (CPB + 4) step();
        n_tests++; if (rx_overflow !== exp_ovf) begin n_fail++; $display("FAIL rxovf_flag: got %b want %b", rx_overflow, exp_ovf); end
        while (model.size() > 0) begin
            d = model.pop_front();
            n_tests++; if (cpu_serial_valid_in !== 1'b1 || cpu_serial_in !== d) begin
                n_fail++; $display("FAIL rxovf_read: got v=%b %h want v=1 %h", cpu_serial_valid_in, cpu_serial_in, d); end
            cpu_read();
        end
        n_tests++; if (cpu_serial_valid_in !== 1'b0) begin n_fail++; $display("FAIL rxovf_drained: valid %b want 0", cpu_serial_valid_in); end
    endtask

    task automatic test_errors();
        pulse_clr();
        n_tests++; if ({rx_overflow, tx_overflow, frame_error} !== 3'b000) begin
            n_fail++; $display("FAIL clr_status: flags %b want 000", {rx_overflow, tx_overflow, frame_error}); end
        send_rx(8'hC3, 1'b0);
        uart_rx_in = 1'b1;
        repeat (10) step();
        n_tests++; if (frame_error !== 1'b1) begin n_fail++; $display("FAIL bad_stop_flag: got %b want 1", frame_error); end
        n_tests++; if (cpu_serial_valid_in !== 1'b0) begin n_fail++; $display("FAIL bad_stop_push: valid %b want 0", cpu_serial_valid_in); end
        pulse_clr();
        uart_rx_in = 1'b0;
        step();
        uart_rx_in = 1'b1;
        repeat (3 * CPB + 8) step();
        n_tests++; if (cpu_serial_valid_in !== 1'b0) begin n_fail++; $display("FAIL glitch_push: valid %b want 0", cpu_serial_valid_in); end
        n_tests++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL glitch_error: got %b want 0", frame_error); end
    endtask

    task automatic test_random();
        logic [7:0] model[$];
        logic [7:0] d;
        for (int r = 0; r < 2; r++) begin
            tx_seen.delete();
            model.delete();
            for (int i = 0; i < 3; i++) begin
                d = 8'($urandom_range(0, 255));
                model.push_back(d);
                cpu_write(d);
            end
            repeat (3 * NBITS * CPB + 20) step();
            n_tests++; if (tx_seen.size() != 3) begin n_fail++; $display("FAIL rand_tx_count_%0d: got %0d want 3", r, tx_seen.size()); end
            for (int i = 0; i < 3 && i < tx_seen.size(); i++) begin
                n_tests++; if (tx_seen[i] !== model[i]) begin n_fail++; $display("FAIL rand_tx_byte_%0d_%0d: got %h want %h", r, i, tx_seen[i], model[i]); end
            end
            model.delete();
            for (int i = 0; i < 3; i++) begin
                d = 8'($urandom_range(0, 255));
                model.push_back(d);
                send_rx(d, 1'b1);
            end
            uart_rx_in = 1'b1;
            repeat (CPB + 4) step();
            while (model.size() > 0) begin
                d = model.pop_front();
                n_tests++; if (cpu_serial_valid_in !== 1'b1 || cpu_serial_in !== d) begin
                    n_fail++; $display("FAIL rand_rx_%0d: got v=%b %h want v=1 %h", r, cpu_serial_valid_in, cpu_serial_in, d); end
                cpu_read();
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] a;
        int lows;
        a = 8'h08;
        tx_seen.delete();
        cpu_write(a);
        cpu_write(8'h77);
        for (int i = 0; i < 18; i++) begin
            uart_rx_in = frame_bit(8'h00, i / CPB);
            step();
        end
        n_tests++; if (uart_tx_out !== a[3]) begin n_fail++; $display("FAIL mid_data_bit3: line %b want %b", uart_tx_out, a[3]); end
        reset = 1'b0;
        uart_rx_in = 1'b1;
        step();
        n_tests++; if (uart_tx_out !== 1'b1) begin n_fail++; $display("FAIL mid_reset_line: got %b want 1", uart_tx_out); end
        n_tests++; if (cpu_serial_ready_in !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: got %b want 1", cpu_serial_ready_in); end
        reset = 1'b1;
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (uart_tx_out !== 1'b1) lows++;
        end
        n_tests++; if (lows != 0) begin n_fail++; $display("FAIL mid_no_more_bits: %0d low cycles want 0", lows); end
        n_tests++; if (cpu_serial_valid_in !== 1'b0) begin n_fail++; $display("FAIL mid_rx_partial: valid %b want 0", cpu_serial_valid_in); end
        n_tests++; if (tx_seen.size() != 0) begin n_fail++; $display("FAIL mid_tx_frames: got %0d want 0", tx_seen.size()); end
    endtask

    initial begin
        test_reset();
        test_tx();
        test_rx();
        test_tx_overflow();
        test_rx_overflow();
        test_errors();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
